// File: rtl/load_align_unit_if.sv
// Load-path bus between the data-memory read port and the load_align_unit.
// master = request producer / result consumer, slave = the align unit.
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_offset;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;
  logic [CNT_W-1:0]  misalign_cnt;

  modport master (
    output in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_misalign, misalign_cnt
  );

  modport slave (
    input  in_valid, in_data, in_offset, in_size, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_misalign, misalign_cnt
  );
endinterface

// File: rtl/load_align_unit.sv
// Load aligner: extracts and extends the addressed byte/half/word/dword,
// flags misaligned or illegal accesses, and buffers results in a 2-entry FIFO.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  load_align_unit_if.slave bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              misalign;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  occ_t              state_q, state_d;
  entry_t            head_q, tail_q, new_entry;
  logic [CNT_W-1:0]  cnt_q;
  logic              push, pop;
  logic [DATA_W-1:0] shifted, mask, extended;
  logic              sign_bit, misalign;
  logic [OFF_W-1:0]  low_mask;

  // Ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready     = (state_q != FULL) && !reset;
  assign bus.out_valid    = (state_q != EMPTY);
  assign bus.out_data     = head_q.data;
  assign bus.out_misalign = head_q.misalign;
  assign bus.misalign_cnt = cnt_q;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Field mask and sign position follow the access size; dword uses the full word.
  always_comb begin
    shifted  = bus.in_data >> {bus.in_offset, 3'b000};
    mask     = '1;
    sign_bit = shifted[DATA_W-1];
    case (bus.in_size)
      2'd0: begin
        mask     = DATA_W'(8'hFF);
        sign_bit = shifted[7];
      end
      2'd1: begin
        mask     = DATA_W'(16'hFFFF);
        sign_bit = shifted[15];
      end
      2'd2: begin
        mask     = DATA_W'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
    extended = shifted & mask;
    if (sign_bit && !bus.in_unsigned) begin
      extended = extended | ~mask;
    end
    low_mask = OFF_W'((32'd1 << bus.in_size) - 32'd1);
    misalign = (|(bus.in_offset & low_mask)) ||
               ((bus.in_size == 2'd3) && (DATA_W == 32));
    new_entry.data     = misalign ? '0 : extended;
    new_entry.misalign = misalign;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // The head register always feeds the outputs; the tail only holds a second entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        EMPTY: if (push) head_q <= new_entry;
        ONE: begin
          if (push && pop) begin
            head_q <= new_entry;
          end else if (push) begin
            tail_q <= new_entry;
          end
        end
        FULL: if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (push && new_entry.misalign && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: a 32-bit and a 64-bit (narrow counter) instance
// checked every cycle against a queue-based reference model plus fixed vectors.
module tb_load_align_unit;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [63:0] data;
    bit          mis;
  } entry_t;

  typedef struct {
    int          sel;
    logic [63:0] data;
    int          off;
    int          size;
    bit          uns;
    logic [63:0] exp_data;
    bit          exp_mis;
  } vec_t;

  entry_t mq[2][$];
  int     mcnt[2];
  int     cmax[2] = '{65535, 15};
  bit     last_acc[2];

  load_align_unit_if #(.DATA_W(32), .CNT_W(16)) if32 ();
  load_align_unit_if #(.DATA_W(64), .CNT_W(4))  if64 ();

  load_align_unit #(.DATA_W(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .bus(if32)
  );
  load_align_unit #(.DATA_W(64), .CNT_W(4)) dut64 (
    .clk(clk), .reset(reset), .bus(if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog");
  end

  // Expected result straight from the access rules, in plain 64-bit arithmetic.
  function automatic entry_t ref_align(int w, logic [63:0] d, int off, int size, bit uns);
    entry_t      e;
    int          nbytes;
    logic [63:0] mask, wmask, sh;
    nbytes = 1 << size;
    wmask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if ((size == 3 && w == 32) || (off % nbytes) != 0) begin
      e.data = 64'd0;
      e.mis  = 1'b1;
      return e;
    end
    sh     = (d & wmask) >> (8 * off);
    mask   = (nbytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nbytes)) - 64'd1);
    e.data = sh & mask;
    if (!uns && sh[8*nbytes-1]) e.data = e.data | ~mask;
    e.data = e.data & wmask;
    e.mis  = 1'b0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int sel, input bit v, input logic [63:0] d,
                               input int off, input int size, input bit uns);
    if (sel == 0) begin
      if32.in_valid    = v;
      if32.in_data     = d[31:0];
      if32.in_offset   = 2'(off);
      if32.in_size     = 2'(size);
      if32.in_unsigned = uns;
    end else begin
      if64.in_valid    = v;
      if64.in_data     = d;
      if64.in_offset   = 3'(off);
      if64.in_size     = 2'(size);
      if64.in_unsigned = uns;
    end
  endtask

  task automatic get_in(input int sel, output bit v, output logic [63:0] d, output int off,
                        output int size, output bit uns, output bit ordy);
    if (sel == 0) begin
      v = if32.in_valid; d = 64'(if32.in_data); off = int'(if32.in_offset);
      size = int'(if32.in_size); uns = if32.in_unsigned; ordy = if32.out_ready;
    end else begin
      v = if64.in_valid; d = if64.in_data; off = int'(if64.in_offset);
      size = int'(if64.in_size); uns = if64.in_unsigned; ordy = if64.out_ready;
    end
  endtask

  task automatic get_out(input int sel, output bit ir, output bit ov, output bit om,
                         output logic [63:0] od, output int mc);
    if (sel == 0) begin
      ir = if32.in_ready; ov = if32.out_valid; om = if32.out_misalign;
      od = 64'(if32.out_data); mc = int'(if32.misalign_cnt);
    end else begin
      ir = if64.in_ready; ov = if64.out_valid; om = if64.out_misalign;
      od = if64.out_data; mc = int'(if64.misalign_cnt);
    end
  endtask

  // One clock: predict handshakes, advance the model, compare both instances.
  task automatic step();
    bit          acc[2];
    bit          pop[2];
    entry_t      nxt[2];
    bit          v, uns, ordy, ir, ov, om;
    logic [63:0] d, od;
    int          off, size, mc;
    for (int s = 0; s < 2; s++) begin
      get_in(s, v, d, off, size, uns, ordy);
      acc[s] = v && (mq[s].size() < 2) && !reset;
      pop[s] = (mq[s].size() > 0) && ordy && !reset;
      nxt[s] = ref_align((s == 0) ? 32 : 64, d, off, size, uns);
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (reset) begin
        mq[s].delete();
        mcnt[s] = 0;
      end else begin
        if (pop[s]) void'(mq[s].pop_front());
        if (acc[s]) begin
          mq[s].push_back(nxt[s]);
          if (nxt[s].mis && mcnt[s] < cmax[s]) mcnt[s]++;
        end
      end
      get_out(s, ir, ov, om, od, mc);
      checkOutput($sformatf("in_ready[%0d]", s), 64'(ir), 64'((mq[s].size() != 2) && !reset));
      checkOutput($sformatf("out_valid[%0d]", s), 64'(ov), 64'(mq[s].size() != 0));
      checkOutput($sformatf("misalign_cnt[%0d]", s), 64'(mc), 64'(mcnt[s]));
      if (mq[s].size() != 0) begin
        checkOutput($sformatf("out_data[%0d]", s), od, mq[s][0].data);
        checkOutput($sformatf("out_misalign[%0d]", s), 64'(om), 64'(mq[s][0].mis));
      end
    end
  endtask

  task automatic check_idle_outputs(input int sel, input string tag);
    bit          ir, ov, om;
    logic [63:0] od;
    int          mc;
    get_out(sel, ir, ov, om, od, mc);
    checkOutput({tag, "_in_ready"}, 64'(ir), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(ov), 64'd0);
    checkOutput({tag, "_out_data"}, od, 64'd0);
    checkOutput({tag, "_out_misalign"}, 64'(om), 64'd0);
    checkOutput({tag, "_misalign_cnt"}, 64'(mc), 64'd0);
  endtask

  initial begin
    vec_t        vt[$];
    bit          ir, ov, om;
    logic [63:0] od;
    int          mc, nacc, sz, off;

    vt.push_back('{0, 64'h80FF7F01, 0, 0, 1'b0, 64'h00000001, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 1, 0, 1'b0, 64'h0000007F, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 2, 0, 1'b0, 64'hFFFFFFFF, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 3, 0, 1'b0, 64'hFFFFFF80, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 0, 0, 1'b1, 64'h00000001, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 1, 0, 1'b1, 64'h0000007F, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 2, 0, 1'b1, 64'h000000FF, 1'b0});
    vt.push_back('{0, 64'h80FF7F01, 3, 0, 1'b1, 64'h00000080, 1'b0});
    vt.push_back('{0, 64'h8001ABCD, 2, 1, 1'b0, 64'hFFFF8001, 1'b0});
    vt.push_back('{0, 64'h8001ABCD, 0, 1, 1'b1, 64'h0000ABCD, 1'b0});
    vt.push_back('{0, 64'h8001ABCD, 0, 2, 1'b0, 64'h8001ABCD, 1'b0});
    vt.push_back('{0, 64'h8001ABCD, 0, 2, 1'b1, 64'h8001ABCD, 1'b0});
    vt.push_back('{0, 64'h8001ABCD, 1, 1, 1'b0, 64'h0, 1'b1});
    vt.push_back('{0, 64'h8001ABCD, 2, 2, 1'b0, 64'h0, 1'b1});
    vt.push_back('{0, 64'h8001ABCD, 0, 3, 1'b0, 64'h0, 1'b1});
    vt.push_back('{1, 64'h0123456780FF7F01, 0, 0, 1'b0, 64'h0000000000000001, 1'b0});
    vt.push_back('{1, 64'h0123456780FF7F01, 1, 0, 1'b0, 64'h000000000000007F, 1'b0});
    vt.push_back('{1, 64'h0123456780FF7F01, 2, 0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0});
    vt.push_back('{1, 64'h0123456780FF7F01, 3, 0, 1'b0, 64'hFFFFFFFFFFFFFF80, 1'b0});
    vt.push_back('{1, 64'h0123456780FF7F01, 2, 0, 1'b1, 64'h00000000000000FF, 1'b0});
    vt.push_back('{1, 64'h0123456780FF7F01, 3, 0, 1'b1, 64'h0000000000000080, 1'b0});
    vt.push_back('{1, 64'h000000008001ABCD, 2, 1, 1'b0, 64'hFFFFFFFFFFFF8001, 1'b0});
    vt.push_back('{1, 64'h000000008001ABCD, 0, 1, 1'b1, 64'h000000000000ABCD, 1'b0});
    vt.push_back('{1, 64'h000000008001ABCD, 0, 2, 1'b0, 64'hFFFFFFFF8001ABCD, 1'b0});
    vt.push_back('{1, 64'h000000008001ABCD, 0, 2, 1'b1, 64'h000000008001ABCD, 1'b0});
    vt.push_back('{1, 64'h8001ABCD00000000, 4, 2, 1'b0, 64'hFFFFFFFF8001ABCD, 1'b0});
    vt.push_back('{1, 64'h876543210FEDCBA9, 0, 3, 1'b0, 64'h876543210FEDCBA9, 1'b0});
    vt.push_back('{1, 64'h876543210FEDCBA9, 4, 3, 1'b0, 64'h0, 1'b1});

    reset = 1'b0;
    applyStimulus(0, 1'b0, 64'd0, 0, 0, 1'b0);
    applyStimulus(1, 1'b0, 64'd0, 0, 0, 1'b0);
    if32.out_ready = 1'b1;
    if64.out_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    check_idle_outputs(0, "por32");
    check_idle_outputs(1, "por64");
    step();
    reset = 1'b0;
    step();

    // Fixed vectors: one request each, result expected right after its accept edge.
    foreach (vt[i]) begin
      applyStimulus(vt[i].sel, 1'b1, vt[i].data, vt[i].off, vt[i].size, vt[i].uns);
      step();
      get_out(vt[i].sel, ir, ov, om, od, mc);
      checkOutput($sformatf("vec%0d_valid", i), 64'(ov), 64'd1);
      checkOutput($sformatf("vec%0d_data", i), od, vt[i].exp_data);
      checkOutput($sformatf("vec%0d_misalign", i), 64'(om), 64'(vt[i].exp_mis));
      applyStimulus(vt[i].sel, 1'b0, 64'd0, 0, 0, 1'b0);
    end
    step();
    get_out(0, ir, ov, om, od, mc);
    checkOutput("misalign_cnt32_after_vectors", 64'(mc), 64'd3);

    // Narrow counter on the 64-bit instance must stop at all-ones.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1'b1, {$urandom, $urandom}, 1, 1, 1'b0);
      step();
    end
    applyStimulus(1, 1'b0, 64'd0, 0, 0, 1'b0);
    step();
    get_out(1, ir, ov, om, od, mc);
    checkOutput("misalign_cnt64_saturated", 64'(mc), 64'd15);

    // Backpressure: three requests offered, only two fit.
    if32.out_ready = 1'b0;
    applyStimulus(0, 1'b1, 64'hAAAA0001, 0, 2, 1'b0);
    step();
    applyStimulus(0, 1'b1, 64'hBBBB0002, 0, 2, 1'b0);
    step();
    get_out(0, ir, ov, om, od, mc);
    checkOutput("bp_in_ready_full", 64'(ir), 64'd0);
    applyStimulus(0, 1'b1, 64'hCCCC0003, 0, 2, 1'b0);
    step();
    step();
    get_out(0, ir, ov, om, od, mc);
    checkOutput("bp_head_stable", od, 64'hAAAA0001);
    checkOutput("bp_still_blocked", 64'(ir), 64'd0);
    if32.out_ready = 1'b1;
    step();
    get_out(0, ir, ov, om, od, mc);
    checkOutput("bp_second_head", od, 64'hBBBB0002);
    checkOutput("bp_ready_after_pop", 64'(ir), 64'd1);
    step();
    checkOutput("bp_third_accepted", 64'(last_acc[0]), 64'd1);
    get_out(0, ir, ov, om, od, mc);
    checkOutput("bp_third_head", od, 64'hCCCC0003);
    applyStimulus(0, 1'b0, 64'd0, 0, 0, 1'b0);
    step();
    get_out(0, ir, ov, om, od, mc);
    checkOutput("bp_drained", 64'(ov), 64'd0);

    // Streaming: one aligned request per cycle with the consumer always ready.
    nacc = 0;
    for (int i = 0; i < 20; i++) begin
      sz  = $urandom_range(0, 2);
      off = ($urandom_range(0, 3) >> sz) << sz;
      applyStimulus(0, 1'b1, 64'($urandom), off, sz, 1'($urandom_range(0, 1)));
      checkOutput($sformatf("stream%0d_in_ready", i), 64'(if32.in_ready), 64'd1);
      step();
      if (last_acc[0]) nacc++;
      checkOutput($sformatf("stream%0d_out_valid", i), 64'(if32.out_valid), 64'd1);
    end
    applyStimulus(0, 1'b0, 64'd0, 0, 0, 1'b0);
    step();
    checkOutput("stream_accept_count", 64'(nacc), 64'd20);

    // Reset with two entries buffered: everything clears at once.
    if32.out_ready = 1'b0;
    applyStimulus(0, 1'b1, 64'h12345678, 0, 2, 1'b0);
    step();
    applyStimulus(0, 1'b1, 64'h9ABCDEF0, 1, 0, 1'b0);
    step();
    applyStimulus(0, 1'b0, 64'd0, 0, 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs(0, "rst32");
    mq[0].delete(); mq[1].delete();
    mcnt[0] = 0; mcnt[1] = 0;
    step();
    reset = 1'b0;
    if32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      get_out(0, ir, ov, om, od, mc);
      checkOutput($sformatf("post_rst%0d_in_ready", i), 64'(ir), 64'd1);
      checkOutput($sformatf("post_rst%0d_no_stale", i), 64'(ov), 64'd0);
    end

    // Random traffic on both instances against the model.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 64'($urandom), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      applyStimulus(1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom_range(0, 7),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if32.out_ready = 1'($urandom_range(0, 1));
      if64.out_ready = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised, registered successor to the word/low-byte selector on the processor load path. It takes a raw memory word, the low address bits and the access size and signedness, then extracts the addressed byte, half or word (or doubleword at DATA_W=64). It sign- or zero-extends the result, flags misaligned or illegal accesses, and delivers results through a 2-entry valid/ready output buffer. It sits between the data-memory read port and the register-file write-back mux.

## Interface
- DATA_W, 32, datapath width; legal values 32 or 64.
- OFF_W, log2(DATA_W/8), width of the byte-offset input; derived, not overridden.
- CNT_W, 16, width of the misalignment event counter.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_data  input  DATA_W  raw memory word.
- in_offset  input  OFF_W  byte address bits [OFF_W-1:0].
- in_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- in_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- out_valid  output  1  result present at buffer head.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  DATA_W  aligned and extended result.
- out_misalign  output  1  head entry was misaligned or illegal.
- misalign_cnt  output  CNT_W  saturating count of accepted misaligned or illegal requests.

## Operation
- Accept condition: in_valid && in_ready.
- Result computation on accept:
  - shifted = in_data >> (8*in_offset).
  - Field width: 8 / 16 / 32 / 64 bits for in_size 0 / 1 / 2 / 3.
  - Field is taken from the LSBs of shifted and extended to DATA_W. Sign-extension uses the field MSB; in_unsigned=1 forces zero-extension.
  - in_size=2 with DATA_W=32 equals in_data, whatever in_unsigned is.
- Misalignment: in_offset not a multiple of the field byte count. Illegal access: in_size=3 with DATA_W=32.
  - Either case stores out_data=0 and out_misalign=1.
  - Either case increments misalign_cnt, which saturates at all-ones.
- Buffer: 2-entry FIFO of {data, misalign} with an occupancy count of 0..2.
  - Push on accept; pop on out_valid && out_ready.
  - Head drives out_data/out_misalign.
- in_ready = (count != 2) && !reset. It depends only on registered state, so there is no combinational path from out_ready.
- out_valid = (count != 0).
- Simultaneous push and pop:
  - count 1: count stays 1; the new entry becomes the head on the next cycle.
  - count 2: push is impossible since in_ready=0; the pop takes effect and count becomes 1.
- Order is strictly FIFO. Head data holds stable while out_valid && !out_ready.

## Timing
- Latency: a request accepted at edge N with an empty buffer is visible at out_valid/out_data right after edge N (one register stage).
- Throughput: one result per cycle while out_ready=1.
- Reset (asynchronous assert, synchronous-release safe): values apply immediately on assert.
  - count=0, out_valid=0, out_data=0, out_misalign=0, misalign_cnt=0.
  - in_ready=0 while reset is high.
- Reset mid-operation: buffered entries are discarded and never appear after release.
- With out_ready=0, at most 2 requests are accepted; in_ready drops the cycle after the second accept.
- misalign_cnt updates on the edge that accepts the offending request.

## Test plan
- Byte load, DATA_W=32: in_data=0x80FF7F01, offsets 0..3, size 0, in_unsigned=0 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. Repeat with in_unsigned=1 → 0x01, 0x7F, 0xFF, 0x80.
- Half/word: in_data=0x8001ABCD, size 1, offset 2, signed → 0xFFFF8001; size 1, offset 0, unsigned → 0x0000ABCD; size 2, offset 0 → 0x8001ABCD.
- Misalign: size 1 offset 1, size 2 offset 2, and size 3 (DATA_W=32), all accepted → out_data=0, out_misalign=1 each time, misalign_cnt=3. Force the counter to 0xFFFF → it stays 0xFFFF.
- Backpressure: out_ready=0, offer 3 back-to-back requests → exactly 2 accepted and in_ready=0. Raise out_ready → results emerge in order, and the third request is accepted the cycle after the first pop.
- Streaming: out_ready=1, one request per cycle for 20 cycles → 20 outputs, 1-cycle latency, in_ready constantly 1.
- Reset with 2 entries buffered → out_valid=0 and misalign_cnt=0 immediately. After release, in_ready=1 and no stale output appears. Also run the first two scenarios at DATA_W=64, including a size 3 signed dword at offset 0.
